// File: rtl/peripheral_ahb3_pkg.sv
// rtl/peripheral_ahb3_pkg.sv - shared AHB3 encodings and slave state enum
package peripheral_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

endpackage

// File: rtl/peripheral_mpram_ahb3_be_gen.sv
// rtl/peripheral_mpram_ahb3_be_gen.sv - byte-enable and alignment check for one AHB address phase
// Ports:
//   hsize_i   - AHB HSIZE of the address phase
//   addr_lo_i - byte offset of HADDR inside one data word
//   be_o      - one bit per byte lane covered by the transfer
//   illegal_o - transfer wider than the bus or misaligned to its size
module peripheral_mpram_ahb3_be_gen #(
    parameter  int DBITS  = 32,
    localparam int BE_W   = DBITS / 8,
    localparam int OFFS   = $clog2(BE_W),
    localparam int OFFS_W = (OFFS > 0) ? OFFS : 1
) (
    input  logic [2:0]        hsize_i,
    input  logic [OFFS_W-1:0] addr_lo_i,
    output logic [BE_W-1:0]   be_o,
    output logic              illegal_o
);

    int off_w;
    int nbytes_w;

    always_comb begin
        // On an 8-bit bus there is no byte offset; the single addr_lo_i bit is unused.
        off_w    = (OFFS > 0) ? int'({{(32-OFFS_W){1'b0}}, addr_lo_i}) : 0;
        nbytes_w = 1 << hsize_i;
        illegal_o = (int'({29'd0, hsize_i}) > OFFS) || ((off_w % nbytes_w) != 0);
        for (int i = 0; i < BE_W; i++) begin
            be_o[i] = (i >= off_w) && (i < off_w + nbytes_w);
        end
    end

endmodule

// File: rtl/peripheral_mpram_ahb3_slave.sv
// rtl/peripheral_mpram_ahb3_slave.sv - zero-wait AHB3 slave in front of a read-first dual-port RAM
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   HSEL..HREADY                 - AHB3 slave inputs
//   HRDATA, HREADYOUT, HRESP     - AHB3 slave outputs
//   mem_waddr_o/din_o/we_o/be_o  - RAM write port, driven in the write data phase
//   mem_raddr_o, mem_dout_i      - RAM read port, data one cycle after address
module peripheral_mpram_ahb3_slave
    import peripheral_ahb3_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int ABITS      = 10,
    parameter int DBITS      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [ABITS-1:0]      mem_waddr_o,
    output logic [DBITS-1:0]      mem_din_o,
    output logic                  mem_we_o,
    output logic [DBITS/8-1:0]    mem_be_o,
    output logic [ABITS-1:0]      mem_raddr_o,
    input  logic [DBITS-1:0]      mem_dout_i
);

    localparam int BE_W   = DBITS / 8;
    localparam int OFFS   = $clog2(BE_W);
    localparam int OFFS_W = (OFFS > 0) ? OFFS : 1;

    state_t            state_q, state_d;
    logic [ABITS-1:0]  waddr_q, waddr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [BE_W-1:0]   byp_be_q, byp_be_d;
    logic [DBITS-1:0]  byp_data_q, byp_data_d;

    logic              accept;
    logic [ABITS-1:0]  haddr_word;
    logic [OFFS_W-1:0] haddr_lo;
    logic [BE_W-1:0]   be_new;
    logic              illegal;
    logic              unused_haddr;

    assign haddr_word   = HADDR[ABITS+OFFS-1:OFFS];
    assign haddr_lo     = HADDR[OFFS_W-1:0];
    // Upper address bits are outside the RAM window; the word address wraps.
    assign unused_haddr = ^HADDR[HADDR_SIZE-1:ABITS+OFFS];

    peripheral_mpram_ahb3_be_gen #(
        .DBITS (DBITS)
    ) u_be_gen (
        .hsize_i   (HSIZE),
        .addr_lo_i (haddr_lo),
        .be_o      (be_new),
        .illegal_o (illegal)
    );

    // HTRANS[1] covers NONSEQ and SEQ; IDLE and BUSY are ignored.
    // Error states never accept: ERR1 holds HREADY low, ERR2 always drains to IDLE.
    assign accept = ((state_q == ST_IDLE) || (state_q == ST_DATA))
                    && HSEL && HREADY && HTRANS[1];

    always_comb begin
        state_d    = ST_IDLE;
        waddr_d    = waddr_q;
        be_d       = be_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        byp_be_d   = '0;
        byp_data_d = byp_data_q;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_DATA;
                        waddr_d = haddr_word;
                        be_d    = be_new;
                        wr_d    = HWRITE;
                        rd_d    = !HWRITE;
                        // The RAM is read-first: a read issued while the previous
                        // write lands on the same word would see stale bytes, so
                        // capture the write's lanes for the read data phase.
                        if (!HWRITE && wr_q && (haddr_word == waddr_q)) begin
                            byp_be_d   = be_q;
                            byp_data_d = HWDATA;
                        end
                    end
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            waddr_q    <= '0;
            be_q       <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            byp_be_q   <= byp_be_d;
            byp_data_q <= byp_data_d;
        end
    end

    // Outputs are gated with rst_i so a reset edge aborts an in-flight write.
    always_comb begin
        HREADYOUT   = 1'b1;
        HRESP       = HRESP_OKAY;
        if (!rst_i) begin
            if (state_q == ST_ERR1) begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end else if (state_q == ST_ERR2) begin
                HRESP     = HRESP_ERROR;
            end
        end
        mem_we_o    = wr_q && !rst_i;
        mem_be_o    = mem_we_o ? be_q : '0;
        mem_waddr_o = rst_i ? '0 : waddr_q;
        mem_din_o   = HWDATA;
        mem_raddr_o = haddr_word;
        HRDATA      = '0;
        if (rd_q && !rst_i) begin
            for (int i = 0; i < BE_W; i++) begin
                HRDATA[8*i +: 8] = byp_be_q[i] ? byp_data_q[8*i +: 8] : mem_dout_i[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_peripheral_mpram_ahb3_slave.sv
// tb/tb_peripheral_mpram_ahb3_slave.sv - directed self-checking bench for the AHB3 RAM slave
module tb_peripheral_mpram_ahb3_slave;

    logic        clk_i;
    logic        rst_i;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [9:0]  mem_waddr_o;
    logic [31:0] mem_din_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [9:0]  mem_raddr_o;
    logic [31:0] mem_dout_i;

    int checks = 0;
    int errors = 0;

    peripheral_mpram_ahb3_slave #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .ABITS      (10),
        .DBITS      (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .mem_waddr_o (mem_waddr_o),
        .mem_din_o   (mem_din_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_raddr_o (mem_raddr_o),
        .mem_dout_i  (mem_dout_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Read-first RAM model with byte enables, preloaded while load is high.
    logic [31:0] tb_mem [1024];
    logic        load;

    always @(posedge clk_i) begin
        if (load) begin
            for (int a = 0; a < 1024; a++) tb_mem[a] <= 32'h0;
            tb_mem[8]  <= 32'hA1B2C3D4;
            tb_mem[9]  <= 32'h0BADF00D;
            tb_mem[16] <= 32'hC0FFEE00;
            tb_mem[20] <= 32'h5A5A5A5A;
        end else if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) tb_mem[mem_waddr_o][8*b +: 8] <= mem_din_o[8*b +: 8];
        end
        mem_dout_i <= tb_mem[mem_raddr_o];
    end

    typedef struct {
        logic        hsel;
        logic        hready;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [9:0]  exp_waddr;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int N = 19;
    vec_t vecs [N];

    function automatic vec_t mk(input logic hsel, input logic hready, input logic [1:0] htrans,
                                input logic hwrite, input logic [2:0] hsize, input logic [31:0] haddr,
                                input logic [31:0] hwdata, input logic exp_we, input logic [3:0] exp_be,
                                input logic [9:0] exp_waddr, input logic [31:0] exp_rdata);
        vec_t v;
        v.hsel = hsel; v.hready = hready; v.htrans = htrans; v.hwrite = hwrite;
        v.hsize = hsize; v.haddr = haddr; v.hwdata = hwdata; v.exp_we = exp_we;
        v.exp_be = exp_be; v.exp_waddr = exp_waddr; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HADDR = 32'h0;
    endtask

    task automatic drive_addr(input logic [1:0] htrans, input logic hwrite,
                              input logic [2:0] hsize, input logic [31:0] haddr);
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = htrans; HWRITE = hwrite;
        HSIZE = hsize; HADDR = haddr;
    endtask

    // Illegal transfer: ERR1 (stall, ERROR), ERR2 (ready, ERROR), then back to OKAY.
    task automatic err_seq(input string name, input logic [2:0] hsize, input logic [31:0] haddr);
        drive_addr(2'b10, 1'b1, hsize, haddr);
        HWDATA = 32'h0;
        @(posedge clk_i); #1;
        drive_idle();
        HWDATA = 32'hFFFFFFFF;
        @(negedge clk_i);
        check({name, "_err1_ready"}, 32'(HREADYOUT), 32'd0);
        check({name, "_err1_resp"},  32'(HRESP),     32'd1);
        check({name, "_err1_we"},    32'(mem_we_o),  32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check({name, "_err2_ready"}, 32'(HREADYOUT), 32'd1);
        check({name, "_err2_resp"},  32'(HRESP),     32'd1);
        check({name, "_err2_we"},    32'(mem_we_o),  32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check({name, "_idle_ready"}, 32'(HREADYOUT), 32'd1);
        check({name, "_idle_resp"},  32'(HRESP),     32'd0);
        check({name, "_idle_we"},    32'(mem_we_o),  32'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        //                hsel hrdy htrans hwr hsize  haddr          hwdata         we be     waddr  rdata
        vecs[0]  = mk(1, 1, 2'b10, 1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 1, 4'hF, 10'd4,  32'h0);
        vecs[1]  = mk(1, 1, 2'b00, 0, 3'd2, 32'h0000_0000, 32'h0,        0, 4'h0, 10'd0,  32'h0);
        vecs[2]  = mk(1, 1, 2'b10, 0, 3'd2, 32'h0000_0010, 32'h0,        0, 4'h0, 10'd0,  32'hDEADBEEF);
        vecs[3]  = mk(1, 1, 2'b10, 1, 3'd2, 32'h0000_0010, 32'h11223344, 1, 4'hF, 10'd4,  32'h0);
        vecs[4]  = mk(1, 1, 2'b11, 1, 3'd0, 32'h0000_0013, 32'hAA000000, 1, 4'h8, 10'd4,  32'h0);
        vecs[5]  = mk(1, 1, 2'b00, 0, 3'd2, 32'h0000_0000, 32'h0,        0, 4'h0, 10'd0,  32'h0);
        vecs[6]  = mk(1, 1, 2'b10, 0, 3'd2, 32'h0000_0010, 32'h0,        0, 4'h0, 10'd0,  32'hAA223344);
        vecs[7]  = mk(1, 1, 2'b10, 1, 3'd1, 32'h0000_0020, 32'h00005566, 1, 4'h3, 10'd8,  32'h0);
        vecs[8]  = mk(1, 1, 2'b10, 0, 3'd2, 32'h0000_0020, 32'h0,        0, 4'h0, 10'd0,  32'hA1B25566);
        vecs[9]  = mk(1, 1, 2'b10, 1, 3'd0, 32'h0000_0022, 32'h00770000, 1, 4'h4, 10'd8,  32'h0);
        vecs[10] = mk(1, 1, 2'b10, 0, 3'd2, 32'h0000_0020, 32'h0,        0, 4'h0, 10'd0,  32'hA1775566);
        vecs[11] = mk(1, 1, 2'b11, 0, 3'd2, 32'h0000_0024, 32'h0,        0, 4'h0, 10'd0,  32'h0BADF00D);
        vecs[12] = mk(1, 1, 2'b01, 1, 3'd2, 32'h0000_0020, 32'hFFFFFFFF, 0, 4'h0, 10'd0,  32'h0);
        vecs[13] = mk(0, 1, 2'b10, 1, 3'd2, 32'h0000_0020, 32'hFFFFFFFF, 0, 4'h0, 10'd0,  32'h0);
        vecs[14] = mk(1, 0, 2'b10, 1, 3'd2, 32'h0000_0020, 32'hFFFFFFFF, 0, 4'h0, 10'd0,  32'h0);
        vecs[15] = mk(1, 1, 2'b10, 0, 3'd2, 32'h0000_0020, 32'h0,        0, 4'h0, 10'd0,  32'hA1775566);
        vecs[16] = mk(1, 1, 2'b10, 1, 3'd2, 32'h0000_1030, 32'h12345678, 1, 4'hF, 10'd12, 32'h0);
        vecs[17] = mk(1, 1, 2'b10, 0, 3'd2, 32'h0000_0030, 32'h0,        0, 4'h0, 10'd0,  32'h12345678);
        vecs[18] = mk(1, 1, 2'b10, 0, 3'd2, 32'h0000_1030, 32'h0,        0, 4'h0, 10'd0,  32'h12345678);

        rst_i = 1'b1;
        load = 1'b1;
        HWDATA = 32'h0;
        drive_idle();
        repeat (2) @(posedge clk_i);
        #1 load = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 32'(HREADYOUT),  32'd1);
        check("rst_resp",  32'(HRESP),      32'd0);
        check("rst_rdata", HRDATA,          32'h0);
        check("rst_we",    32'(mem_we_o),   32'd0);
        check("rst_be",    32'(mem_be_o),   32'd0);
        check("rst_waddr", 32'(mem_waddr_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Each iteration drives vector i's address phase and checks vector i-1's data phase.
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                HSEL = vecs[i].hsel; HREADY = vecs[i].hready; HTRANS = vecs[i].htrans;
                HWRITE = vecs[i].hwrite; HSIZE = vecs[i].hsize; HADDR = vecs[i].haddr;
            end else begin
                drive_idle();
            end
            HWDATA = (i > 0) ? vecs[i-1].hwdata : 32'h0;
            @(negedge clk_i);
            if (i > 0) begin
                check($sformatf("v%0d_we", i-1),    32'(mem_we_o),  32'(vecs[i-1].exp_we));
                check($sformatf("v%0d_be", i-1),    32'(mem_be_o),  32'(vecs[i-1].exp_be));
                check($sformatf("v%0d_rdata", i-1), HRDATA,         vecs[i-1].exp_rdata);
                check($sformatf("v%0d_ready", i-1), 32'(HREADYOUT), 32'd1);
                check($sformatf("v%0d_resp", i-1),  32'(HRESP),     32'd0);
                if (vecs[i-1].exp_we)
                    check($sformatf("v%0d_waddr", i-1), 32'(mem_waddr_o), 32'(vecs[i-1].exp_waddr));
            end
            @(posedge clk_i); #1;
        end

        err_seq("dword", 3'd3, 32'h0000_0040);
        err_seq("misalign", 3'd2, 32'h0000_0002);
        check("err_mem16", tb_mem[16], 32'hC0FFEE00);
        check("err_mem0",  tb_mem[0],  32'h0);

        // Reset lands in the data phase of a write: the write must be dropped.
        drive_addr(2'b10, 1'b1, 3'd2, 32'h0000_0050);
        @(posedge clk_i); #1;
        drive_idle();
        HWDATA = 32'hFFFF0000;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rstw_we",    32'(mem_we_o),  32'd0);
        check("rstw_ready", 32'(HREADYOUT), 32'd1);
        check("rstw_resp",  32'(HRESP),     32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive_addr(2'b10, 1'b0, 3'd2, 32'h0000_0050);
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        check("rstw_rdata", HRDATA,         32'h5A5A5A5A);
        check("rstw_ready2", 32'(HREADYOUT), 32'd1);
        check("rstw_mem20", tb_mem[20],     32'h5A5A5A5A);
        @(posedge clk_i); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
